// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, long-latency results queue in a FIFO,
// and a starvation counter stalls WB to drain the head. Optional same-cycle bypass: RF_ARB_LL_BYPASS_EN.
module rf_wport_arbiter #(
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_dest,
  input  logic [31:0]                 wb_wdata,
  input  logic [31:0]                 wb_pc,
  output logic                        wb_ready,
  input  logic                        ll_valid,
  input  logic [4:0]                  ll_dest,
  input  logic [31:0]                 ll_wdata,
  input  logic [31:0]                 ll_pc,
  output logic                        ll_ready,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(LL_DEPTH):0]   ll_count,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_wen,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata
);

  localparam int PW = $clog2(LL_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    q_dest [LL_DEPTH];
  logic [31:0]   q_data [LL_DEPTH];
  logic [31:0]   q_pc   [LL_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   mask_q;

  logic          fifo_nonempty;
  logic          starved;
  logic          bypass;
  logic          grant_ll;
  logic          grant_wb;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_next;
  logic [31:0]   mask_next;
  logic [PW-1:0] slot_off;
  logic [4:0]    slot_dest;

  assign fifo_nonempty = (count != '0);
  assign starved       = fifo_nonempty && (starve_cnt == SW'(STARVE_MAX));
  assign ll_ready      = (count != CW'(LL_DEPTH));
  assign wb_ready      = !starved;

`ifdef RF_ARB_LL_BYPASS_EN
  assign bypass = !reset && !fifo_nonempty && !wb_valid && ll_valid && (ll_dest != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Nothing is granted while reset is held, so an in-flight head never leaks out.
  assign grant_ll = !reset && (starved || (!wb_valid && fifo_nonempty));
  assign grant_wb = !reset && !starved && wb_valid;
  assign pop      = grant_ll;
  assign push     = !reset && ll_valid && ll_ready && (ll_dest != 5'd0) && !bypass;

  assign count_next = count + CW'(push) - CW'(pop);
  assign rd_next    = rd_ptr + PW'(pop);

  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    debug_wb_pc = 32'd0;
    if (grant_ll) begin
      rf_we       = 1'b1;
      rf_waddr    = q_dest[rd_ptr];
      rf_wdata    = q_data[rd_ptr];
      debug_wb_pc = q_pc[rd_ptr];
    end else if (grant_wb) begin
      rf_we       = wb_we && (wb_dest != 5'd0);
      rf_waddr    = wb_dest;
      rf_wdata    = wb_wdata;
      debug_wb_pc = wb_pc;
    end else if (bypass) begin
      rf_we       = 1'b1;
      rf_waddr    = ll_dest;
      rf_wdata    = ll_wdata;
      debug_wb_pc = ll_pc;
    end
  end

  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Mask reflects post-edge FIFO contents: a slot is live if it lies within count_next of rd_next.
  always_comb begin
    mask_next = 32'd0;
    slot_off  = '0;
    slot_dest = 5'd0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      slot_off  = PW'(i) - rd_next;
      slot_dest = (push && (wr_ptr == PW'(i))) ? ll_dest : q_dest[i];
      if (CW'(slot_off) < count_next) mask_next[slot_dest] = 1'b1;
    end
    mask_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wr_ptr] <= ll_dest;
      q_data[wr_ptr] <= ll_wdata;
      q_pc[wr_ptr]   <= ll_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      mask_q     <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      mask_q <= mask_next;
      if (!fifo_nonempty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign pending_mask = mask_q;
  assign ll_count     = count;

endmodule
